// File: rtl/srf_pll.sv
// -----------------------------------------------------------------------------
// srf_pll : synchronous-reference-frame PLL. Closes a PI loop on the park
// stage's q component and integrates the resulting angular increment into a
// 16-bit phase angle. The angle feeds back to the park / anti-park transforms.
//
// Ports
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   enable       in   loop run enable (gates acceptance of new samples only)
//   q_in[17:0]   in   signed q component from the park stage
//   q_valid      in   single-cycle strobe qualifying q_in
//   kp[17:0]     in   signed proportional gain, Q5.12 (used in MULT)
//   ki[17:0]     in   signed integral gain, Q5.12 (used in MULT)
//   omega_ff     in   signed feed-forward angle increment (used in UPDATE)
//   theta        out  unsigned phase, full scale 2*pi, wraps modulo 2^16
//   omega        out  signed current angle increment (saturated)
//   theta_valid  out  one-cycle pulse when theta/omega update
//   locked       out  lock indicator
//   overrun      out  sticky: q_valid seen while the pipeline was busy
//
// Handshake: q_valid is a strobe with no back-pressure. A sample is taken only
// when q_valid & enable are high while the FSM is in IDLE. theta_valid pulses
// exactly 3 clocks after the accepting edge, so the maximum rate is one sample
// every 4 clocks. An enabled strobe in any other state is dropped and sets
// overrun until reset.
//
// Optional build macro: SRF_PLL_ANTI_WINDUP_EN
//   When defined, the integrator holds whenever the previous UPDATE saturated
//   omega and the new integral term pushes further in the same direction.
// -----------------------------------------------------------------------------
module srf_pll #(
    parameter int                    DATA_WIDTH     = 18,
    parameter int                    GAIN_SHIFT     = 12,
    parameter logic signed [15:0]    INT_LIMIT      = 16'sd8192,
    parameter logic [DATA_WIDTH-1:0] LOCK_THRESHOLD = 18'd512,
    parameter int                    LOCK_COUNT     = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic                  q_valid,
    input  logic [DATA_WIDTH-1:0] kp,
    input  logic [DATA_WIDTH-1:0] ki,
    input  logic [15:0]           omega_ff,
    output logic [15:0]           theta,
    output logic [15:0]           omega,
    output logic                  theta_valid,
    output logic                  locked,
    output logic                  overrun
);

    localparam int PW = 2*DATA_WIDTH - GAIN_SHIFT;   // shifted product width
    localparam int SW = PW + 2;                       // omega sum width
    localparam int CW = $clog2(LOCK_COUNT + 1);       // lock counter width

    localparam logic signed [PW:0]   ILIM_HI   = (PW+1)'(INT_LIMIT);
    localparam logic signed [PW:0]   ILIM_LO   = -ILIM_HI;
    localparam logic signed [SW-1:0] OMEGA_MAX = SW'(32767);
    localparam logic signed [SW-1:0] OMEGA_MIN = SW'(-32768);

    typedef enum logic [1:0] {IDLE, MULT, INTEG, UPDATE} state_t;

    state_t state, state_next;

    logic signed [DATA_WIDTH-1:0]   err;
    logic signed [PW-1:0]           p_reg, i_reg;
    logic signed [15:0]             integ, integ_next;
    logic signed [2*DATA_WIDTH-1:0] p_full, i_full;
    logic signed [PW:0]             integ_sum;
    logic signed [SW-1:0]           omega_sum;
    logic signed [15:0]             omega_sat;
    logic [DATA_WIDTH:0]            q_ext, q_abs;
    logic [CW-1:0]                  lock_cnt, cnt_next;
    logic                           accept;
    logic                           unused_low_bits;
`ifdef SRF_PLL_ANTI_WINDUP_EN
    logic                           sat_hi, sat_lo;
`endif

    assign accept = (state == IDLE) && q_valid && enable;

    // Full-precision signed products; sign extension first so the 36-bit
    // product is exact.
    assign p_full = $signed({{DATA_WIDTH{kp[DATA_WIDTH-1]}}, kp}) *
                    $signed({{DATA_WIDTH{err[DATA_WIDTH-1]}}, err});
    assign i_full = $signed({{DATA_WIDTH{ki[DATA_WIDTH-1]}}, ki}) *
                    $signed({{DATA_WIDTH{err[DATA_WIDTH-1]}}, err});
    // Fraction bits discarded by the Q5.12 arithmetic shift.
    assign unused_low_bits = ^{p_full[GAIN_SHIFT-1:0], i_full[GAIN_SHIFT-1:0]};

    // |q_in| computed one bit wider so -2^17 does not overflow.
    assign q_ext = {q_in[DATA_WIDTH-1], q_in};
    assign q_abs = q_in[DATA_WIDTH-1] ? (~q_ext) + {{DATA_WIDTH{1'b0}}, 1'b1} : q_ext;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MULT;
            MULT:    state_next = INTEG;
            INTEG:   state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next = '0;
        if (q_abs < {1'b0, LOCK_THRESHOLD}) begin
            if (lock_cnt == CW'(LOCK_COUNT)) cnt_next = lock_cnt;
            else                             cnt_next = lock_cnt + CW'(1);
        end
    end

    // Integrator: sum one bit wider than the term so the clamp sees the true
    // sign before truncation back to 16 bits.
    always_comb begin
        integ_sum = {{(PW-15){integ[15]}}, integ} + {i_reg[PW-1], i_reg};
        if (integ_sum > ILIM_HI)      integ_next = INT_LIMIT;
        else if (integ_sum < ILIM_LO) integ_next = -INT_LIMIT;
        else                          integ_next = integ_sum[15:0];
`ifdef SRF_PLL_ANTI_WINDUP_EN
        if ((sat_hi && !i_reg[PW-1] && (i_reg != '0)) || (sat_lo && i_reg[PW-1]))
            integ_next = integ;
`endif
    end

    always_comb begin
        omega_sum = {{(SW-16){omega_ff[15]}}, omega_ff}
                  + {{(SW-PW){p_reg[PW-1]}}, p_reg}
                  + {{(SW-16){integ[15]}}, integ};
        if (omega_sum > OMEGA_MAX)      omega_sat = 16'sh7FFF;
        else if (omega_sum < OMEGA_MIN) omega_sat = 16'sh8000;
        else                            omega_sat = omega_sum[15:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            err         <= '0;
            p_reg       <= '0;
            i_reg       <= '0;
            integ       <= '0;
            theta       <= '0;
            omega       <= '0;
            theta_valid <= 1'b0;
            locked      <= 1'b0;
            overrun     <= 1'b0;
            lock_cnt    <= '0;
`ifdef SRF_PLL_ANTI_WINDUP_EN
            sat_hi      <= 1'b0;
            sat_lo      <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            theta_valid <= 1'b0;
            if (accept) begin
                err      <= $signed(q_in);
                lock_cnt <= cnt_next;
                locked   <= (cnt_next == CW'(LOCK_COUNT));
            end
            if (q_valid && enable && (state != IDLE))
                overrun <= 1'b1;
            case (state)
                MULT: begin
                    p_reg <= p_full[2*DATA_WIDTH-1:GAIN_SHIFT];
                    i_reg <= i_full[2*DATA_WIDTH-1:GAIN_SHIFT];
                end
                INTEG: integ <= integ_next;
                UPDATE: begin
                    omega       <= omega_sat;
                    theta       <= theta + omega_sat;   // modulo 2^16 wrap
                    theta_valid <= 1'b1;
`ifdef SRF_PLL_ANTI_WINDUP_EN
                    sat_hi      <= (omega_sum > OMEGA_MAX);
                    sat_lo      <= (omega_sum < OMEGA_MIN);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
